// File: rtl/sbus_mem_responder.sv
// sbus_mem_responder -- SBUS memory responder with a MEM_WORDS x 36-bit store.
//
// Accepts one quadword read or write request at a time from MBOX and
// acknowledges it. After ACCESS_DLY wait cycles it transfers each requested
// word back-to-back. The words are visited in wrap order, starting at the
// requested word.
//
// Ports
//   mboxClk        in   clock, rising edge
//   CROBAR         in   async active-high reset
//   sbusStart      in   request strobe (sampled in IDLE only)
//   sbusAdr[21:0]  in   word address; [1:0] = starting word in quadword
//   sbusRq[3:0]    in   word-request mask
//   sbusRdRq       in   read request
//   sbusWrRq       in   write request
//   sbusDin[35:0]  in   write data (sampled at the end of each DataValid cycle)
//   sbusAckn       out  one-cycle acknowledge
//   sbusDataValid  out  per-word transfer strobe
//   sbusDout[35:0] out  read data, zero outside read strobes
//   sbusErr        out  one-cycle reject pulse for a malformed request
//   sbusBusy       out  high whenever not IDLE
module sbus_mem_responder #(
  parameter int MEM_WORDS  = 1024,
  parameter int ACCESS_DLY = 3
) (
  input  logic        mboxClk,
  input  logic        CROBAR,
  input  logic        sbusStart,
  input  logic [21:0] sbusAdr,
  input  logic [3:0]  sbusRq,
  input  logic        sbusRdRq,
  input  logic        sbusWrRq,
  input  logic [35:0] sbusDin,
  output logic        sbusAckn,
  output logic        sbusDataValid,
  output logic [35:0] sbusDout,
  output logic        sbusErr,
  output logic        sbusBusy
);

  localparam int AW = $clog2(MEM_WORDS);

  typedef enum logic [1:0] {IDLE, ACKN, WAIT, XFER} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q,   cnt_d;
  logic [21:0] adr_q,   adr_d;
  logic [3:0]  rem_q,   rem_d;    // requested words not yet transferred
  logic        wr_q,    wr_d;
  logic [1:0]  w_q,     w_d;      // word being transferred this XFER cycle
  logic        ackn_q,  ackn_d;
  logic        dv_q,    dv_d;
  logic        err_q,   err_d;
  logic [35:0] dout_q,  dout_d;

  logic [35:0]   mem_q [MEM_WORDS];
  logic          mem_we;
  logic [AW-1:0] mem_wa;

  logic req_ok;
  assign req_ok = (sbusRdRq ^ sbusWrRq) && (sbusRq != 4'b0000);

  // Store index: the upper address bits replace the low word bits, then the
  // result is truncated to the store depth (aliasing above MEM_WORDS).
  function automatic logic [AW-1:0] word_idx(input logic [21:0] adr, input logic [1:0] w);
    logic [21:0] full;
    full = {adr[21:2], w};
    return full[AW-1:0];
  endfunction

  // Returns the first set mask bit at or after p, wrapping modulo 4.
  // Words with a clear mask bit are skipped here, so they cost no cycle.
  function automatic logic [1:0] first_set(input logic [3:0] m, input logic [1:0] p);
    logic [1:0] q;
    logic [1:0] r;
    r = p;
    for (int k = 3; k >= 0; k--) begin
      q = p + 2'(k);
      if (m[q]) r = q;
    end
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    adr_d   = adr_q;
    rem_d   = rem_q;
    wr_d    = wr_q;
    w_d     = w_q;
    ackn_d  = 1'b0;
    dv_d    = 1'b0;
    err_d   = 1'b0;
    dout_d  = '0;
    mem_we  = 1'b0;
    mem_wa  = word_idx(adr_q, w_q);

    case (state_q)
      IDLE: begin
        if (sbusStart) begin
          if (req_ok) begin
            adr_d   = sbusAdr;
            rem_d   = sbusRq;
            wr_d    = sbusWrRq;
            ackn_d  = 1'b1;
            state_d = ACKN;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ACKN: begin
        cnt_d   = 4'(ACCESS_DLY);
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        // Counter hits 0 on this edge, so the strobe is registered
        // together with the XFER entry.
        if (cnt_q == 4'd1) begin
          state_d = XFER;
          w_d     = first_set(rem_q, adr_q[1:0]);
          dv_d    = 1'b1;
        end
      end
      XFER: begin
        mem_we = wr_q;
        rem_d  = rem_q & ~(4'b0001 << w_q);
        if (rem_d == 4'b0000) begin
          state_d = IDLE;
        end else begin
          w_d  = first_set(rem_d, 2'(w_q + 2'd1));
          dv_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Read data is fetched one edge early so that it is registered with the strobe.
    if (dv_d && !wr_q) dout_d = mem_q[word_idx(adr_q, w_d)];
  end

  always_ff @(posedge mboxClk or posedge CROBAR) begin
    if (CROBAR) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      adr_q   <= '0;
      rem_q   <= '0;
      wr_q    <= 1'b0;
      w_q     <= '0;
      ackn_q  <= 1'b0;
      dv_q    <= 1'b0;
      err_q   <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      adr_q   <= adr_d;
      rem_q   <= rem_d;
      wr_q    <= wr_d;
      w_q     <= w_d;
      ackn_q  <= ackn_d;
      dv_q    <= dv_d;
      err_q   <= err_d;
      dout_q  <= dout_d;
    end
  end

  // Backing store is never reset; a reset holds state_q in IDLE, so no write
  // can land while CROBAR is high.
  always_ff @(posedge mboxClk) begin
    if (mem_we) mem_q[mem_wa] <= sbusDin;
  end

  assign sbusAckn      = ackn_q;
  assign sbusDataValid = dv_q;
  assign sbusErr       = err_q;
  assign sbusDout      = dout_q;
  assign sbusBusy      = (state_q != IDLE);

endmodule

// File: tb/tb_sbus_mem_responder.sv
module tb_sbus_mem_responder;
  localparam int D  = 3;
  localparam int MW = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        sbusStart, sbusRdRq, sbusWrRq;
  logic [21:0] sbusAdr;
  logic [3:0]  sbusRq;
  logic [35:0] sbusDin;
  logic        sbusAckn, sbusDataValid, sbusErr, sbusBusy;
  logic [35:0] sbusDout;

  always #5 clk = ~clk;

  sbus_mem_responder #(.MEM_WORDS(MW), .ACCESS_DLY(D)) dut (
    .mboxClk(clk), .CROBAR(rst), .sbusStart(sbusStart), .sbusAdr(sbusAdr),
    .sbusRq(sbusRq), .sbusRdRq(sbusRdRq), .sbusWrRq(sbusWrRq), .sbusDin(sbusDin),
    .sbusAckn(sbusAckn), .sbusDataValid(sbusDataValid), .sbusDout(sbusDout),
    .sbusErr(sbusErr), .sbusBusy(sbusBusy)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [35:0] model [int];
  logic [35:0] exp_q [$];
  logic [35:0] wq [$];

  task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issues one request (called right after a negedge) and checks it cycle by cycle.
  // stray_cyc: cycle at which a stray Start is raised (0 = none).
  // abort_n:   pulse reset once abort_n words have been written (0 = none).
  task automatic run_req(input logic [21:0] adr, input logic [3:0] rq, input logic wr,
                         input logic [35:0] d0, input logic [35:0] d1,
                         input logic [35:0] d2, input logic [35:0] d3,
                         input int stray_cyc, input int abort_n);
    logic [35:0] dat [4];
    logic [21:0] full;
    int n, w, idx;
    bit in_xfer;
    dat = '{d0, d1, d2, d3};
    n = 0;
    exp_q.delete();
    wq.delete();
    for (int k = 0; k < 4; k++) begin
      w = (int'(adr[1:0]) + k) % 4;
      if (rq[w]) begin
        full = {adr[21:2], 2'(w)};
        idx = int'(full) % MW;
        if (wr) begin
          wq.push_back(dat[w]);
          if (abort_n == 0 || n < abort_n) model[idx] = dat[w];
        end else begin
          exp_q.push_back(model[idx]);
        end
        n++;
      end
    end
    sbusAdr = adr; sbusRq = rq; sbusWrRq = wr; sbusRdRq = !wr; sbusStart = 1'b1;
    for (int c = 1; c <= D + 2 + n; c++) begin
      @(negedge clk);
      sbusStart = 1'b0;
      if (c == stray_cyc) begin
        sbusStart = 1'b1; sbusRdRq = 1'b0; sbusWrRq = 1'b1; sbusRq = 4'hF;
      end
      if (abort_n > 0 && c == D + 2 + abort_n) begin
        rst = 1'b1;
        #1;
        chk("abort_ackn", sbusAckn, 0);
        chk("abort_dv",   sbusDataValid, 0);
        chk("abort_err",  sbusErr, 0);
        chk("abort_busy", sbusBusy, 0);
        chk("abort_dout", sbusDout, 0);
        @(negedge clk);
        rst = 1'b0;
        chk("abort_dv2",   sbusDataValid, 0);
        chk("abort_busy2", sbusBusy, 0);
        return;
      end
      in_xfer = (c >= D + 2) && (c <= D + 1 + n);
      chk("ackn", sbusAckn, 36'(c == 1));
      chk("err",  sbusErr, 0);
      chk("dv",   sbusDataValid, 36'(in_xfer));
      chk("busy", sbusBusy, 36'(c <= D + 1 + n));
      if (sbusDataValid === 1'b1 && !wr) begin
        if (exp_q.size() > 0) chk("rdata", sbusDout, exp_q.pop_front());
        else chk("extra_strobe", sbusDataValid, 0);
      end else begin
        chk("dout_idle", sbusDout, 0);
      end
      if (sbusDataValid === 1'b1 && wr && wq.size() > 0) sbusDin = wq.pop_front();
    end
    chk("rd_left", 36'(exp_q.size()), 0);
  endtask

  task automatic bad_req(input logic rd, input logic wr, input logic [3:0] rq);
    sbusAdr = 22'h000010; sbusRq = rq; sbusRdRq = rd; sbusWrRq = wr; sbusStart = 1'b1;
    @(negedge clk);
    sbusStart = 1'b0;
    chk("err_pulse", sbusErr, 1);
    chk("err_ackn",  sbusAckn, 0);
    chk("err_dv",    sbusDataValid, 0);
    chk("err_busy",  sbusBusy, 0);
    @(negedge clk);
    chk("err_once",  sbusErr, 0);
    chk("err_busy2", sbusBusy, 0);
    chk("err_ackn2", sbusAckn, 0);
  endtask

  initial begin
    rst = 1'b0; sbusStart = 1'b0; sbusRdRq = 1'b0; sbusWrRq = 1'b0;
    sbusAdr = '0; sbusRq = '0; sbusDin = '0;
    #2 rst = 1'b1;
    #1;
    chk("rst_ackn", sbusAckn, 0);
    chk("rst_dv",   sbusDataValid, 0);
    chk("rst_err",  sbusErr, 0);
    chk("rst_busy", sbusBusy, 0);
    chk("rst_dout", sbusDout, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    // Start on the first edge after reset release.
    run_req(22'h000100, 4'hF, 1'b1, 36'hA_0000_000A, 36'hB_0000_000B, 36'hC_0000_000C, 36'hD_0000_000D, 0, 0);
    run_req(22'h000100, 4'hF, 1'b0, 0, 0, 0, 0, 0, 0);
    // Start at word 2 with mask 1011: words 3, 0, 1.
    run_req(22'h000102, 4'b1011, 1'b0, 0, 0, 0, 0, 0, 0);
    bad_req(1'b1, 1'b1, 4'hF);
    bad_req(1'b1, 1'b0, 4'h0);
    // Stray Start during WAIT.
    run_req(22'h000101, 4'hF, 1'b0, 0, 0, 0, 0, 3, 0);
    run_req(22'h000200, 4'hF, 1'b1, 36'h1_1111_1110, 36'h1_1111_1111, 36'h1_1111_1112, 36'h1_1111_1113, 0, 0);
    run_req(22'h000200, 4'hF, 1'b1, 36'hE_EEEE_EEE0, 36'hE_EEEE_EEE1, 36'hE_EEEE_EEE2, 36'hE_EEEE_EEE3, 0, 2);
    run_req(22'h000200, 4'hF, 1'b0, 0, 0, 0, 0, 0, 0);
    // Address aliasing at the top of the address space.
    run_req(22'h3FFFFF, 4'b1000, 1'b1, 0, 0, 0, 36'h5_A5A5_A5A5, 0, 0);
    run_req(22'h0003FF, 4'b1000, 1'b0, 0, 0, 0, 0, 0, 0);
    run_req(22'h000100, 4'b0101, 1'b0, 0, 0, 0, 0, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
